// File: rtl/apu_pkg.sv
// rtl/apu_pkg.sv - order entry layout, scheduler state enums and entry decode helper
package apu_pkg;

    localparam int ORDER_DW = 24;
    localparam int ADDR_LSB = 0;
    localparam int ADDR_W   = 5;
    localparam int LEN_LSB  = 5;
    localparam int LEN_W    = 5;
    localparam int DUR_LSB  = 10;
    localparam int DUR_W    = 12;
    localparam int END_BIT  = 22;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_ARM,
        ST_PLAY
    } sched_state_t;

    typedef enum logic [1:0] {
        PF_EMPTY,
        PF_REQ,
        PF_WAIT,
        PF_FULL
    } pf_state_t;

    typedef struct packed {
        logic              end_flag;
        logic [DUR_W-1:0]  dur;
        logic [LEN_W-1:0]  len;
        logic [ADDR_W-1:0] addr;
    } order_entry_t;

    // A zero duration would never reach a boundary, so it plays as one strobe.
    function automatic order_entry_t decode_entry(input logic [ORDER_DW-1:0] d);
        order_entry_t e;
        e.addr     = d[ADDR_LSB +: ADDR_W];
        e.len      = d[LEN_LSB +: LEN_W];
        e.dur      = d[DUR_LSB +: DUR_W];
        e.end_flag = d[END_BIT];
        if (e.dur == '0) begin
            e.dur = DUR_W'(1);
        end
        return e;
    endfunction

endpackage

// File: rtl/order_prefetch.sv
// rtl/order_prefetch.sv - fetches the next order entry into a shadow register during playback
module order_prefetch
    import apu_pkg::*;
#(
    parameter int ORDER_AW = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                run,
    input  logic                clear,
    input  logic [ORDER_AW-1:0] cur_idx,
    input  logic                cur_end,
    input  logic                loop_en,
    input  logic [ORDER_DW-1:0] order_data,
    input  logic                consume,
    output logic                req,
    output logic [ORDER_AW-1:0] next_idx,
    output logic                full,
    output logic                last,
    output order_entry_t        entry
);

    pf_state_t           st, st_nxt;
    logic [ORDER_AW-1:0] idx_q;
    logic [ORDER_AW-1:0] idx_calc;
    logic                last_q;
    logic                song_end;
    logic                unused_rsvd;

    assign unused_rsvd = order_data[ORDER_DW-1];
    assign song_end    = cur_end && !loop_en;
    assign idx_calc    = cur_end ? '0 : cur_idx + ORDER_AW'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst || clear || !run) begin
            st     <= PF_EMPTY;
            idx_q  <= '0;
            last_q <= 1'b0;
            entry  <= '0;
        end else begin
            st <= st_nxt;
            if (st == PF_EMPTY && !last_q) begin
                idx_q  <= idx_calc;
                last_q <= song_end;
            end
            if (st == PF_WAIT) begin
                entry <= decode_entry(order_data);
            end
        end
    end

    always_comb begin
        st_nxt = st;
        case (st)
            PF_EMPTY: if (!last_q && !song_end) st_nxt = PF_REQ;
            PF_REQ:   st_nxt = PF_WAIT;
            PF_WAIT:  st_nxt = PF_FULL;
            PF_FULL:  if (consume) st_nxt = PF_EMPTY;
            default:  st_nxt = PF_EMPTY;
        endcase
    end

    // The ROM address is held through REQ so WAIT sees data for the same index.
    assign req      = run && (((st == PF_EMPTY) && !last_q && !song_end) || (st == PF_REQ));
    assign next_idx = (st == PF_EMPTY) ? idx_calc : idx_q;
    assign full     = (st == PF_FULL);
    assign last     = last_q || ((st == PF_EMPTY) && song_end);

endmodule

// File: rtl/pattern_scheduler.sv
// rtl/pattern_scheduler.sv - song-level order walker driving the note_sequencer pattern-load port
module pattern_scheduler
    import apu_pkg::*;
#(
    parameter int ORDER_AW = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic                i_loop_en,
    input  logic                i_note_stb,
    output logic [ORDER_AW-1:0] o_order_addr,
    input  logic [ORDER_DW-1:0] i_order_data,
    output logic [ADDR_W-1:0]   o_new_addr,
    output logic [LEN_W-1:0]    o_new_pattern_len,
    output logic                o_new_addr_valid,
    output logic                o_playing,
    output logic [ORDER_AW-1:0] o_order_index
);

    localparam logic [DUR_W-1:0] DUR_ONE = DUR_W'(1);

    sched_state_t        state, state_nxt;
    order_entry_t        cur;
    logic [ORDER_AW-1:0] idx;
    logic [DUR_W-1:0]    tick;
    logic                playing;
    logic                pending;
    logic                at_boundary;
    logic                take;
    logic                stall;
    logic                song_done;
    logic                use_shadow;
    logic                pf_run;
    logic                pf_req;
    logic                pf_full;
    logic                pf_last;
    logic [ORDER_AW-1:0] pf_idx;
    order_entry_t        pf_entry;
    logic                unused_rsvd;

    assign unused_rsvd = i_order_data[ORDER_DW-1];
    assign at_boundary = (tick == cur.dur - DUR_ONE);
    // pending marks an ARM reached from a boundary whose shadow entry was not ready.
    assign use_shadow  = (state == ST_PLAY) || pending;
    assign pf_run      = (state == ST_PLAY) || ((state == ST_ARM) && pending);

    order_prefetch #(.ORDER_AW(ORDER_AW)) u_prefetch (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .run        (pf_run),
        .clear      (i_start || i_stop),
        .cur_idx    (idx),
        .cur_end    (cur.end_flag),
        .loop_en    (i_loop_en),
        .order_data (i_order_data),
        .consume    (take && use_shadow),
        .req        (pf_req),
        .next_idx   (pf_idx),
        .full       (pf_full),
        .last       (pf_last),
        .entry      (pf_entry)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            cur     <= '0;
            idx     <= '0;
            tick    <= '0;
            playing <= 1'b0;
            pending <= 1'b0;
        end else begin
            state <= state_nxt;
            if (i_stop || i_start || song_done) begin
                cur     <= '0;
                idx     <= '0;
                tick    <= '0;
                playing <= 1'b0;
                pending <= 1'b0;
            end else begin
                if (state == ST_LATCH) begin
                    cur <= decode_entry(i_order_data);
                end
                if (take) begin
                    tick    <= '0;
                    playing <= 1'b1;
                    pending <= 1'b0;
                    if (use_shadow) begin
                        cur <= pf_entry;
                        idx <= pf_idx;
                    end
                end else if (stall) begin
                    pending <= 1'b1;
                end else if (state == ST_PLAY && i_note_stb) begin
                    tick <= tick + DUR_ONE;
                end
            end
        end
    end

    always_comb begin
        state_nxt         = state;
        take              = 1'b0;
        stall             = 1'b0;
        song_done         = 1'b0;
        o_new_addr_valid  = 1'b0;
        o_new_addr        = '0;
        o_new_pattern_len = '0;
        case (state)
            ST_IDLE:  if (i_start) state_nxt = ST_FETCH;
            ST_FETCH: state_nxt = ST_LATCH;
            ST_LATCH: state_nxt = ST_ARM;
            ST_ARM: begin
                if (!pending) begin
                    o_new_addr_valid  = 1'b1;
                    o_new_addr        = cur.addr;
                    o_new_pattern_len = cur.len;
                end else if (pf_full) begin
                    o_new_addr_valid  = 1'b1;
                    o_new_addr        = pf_entry.addr;
                    o_new_pattern_len = pf_entry.len;
                end
                if (i_note_stb && o_new_addr_valid) begin
                    take      = 1'b1;
                    state_nxt = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (i_note_stb && at_boundary) begin
                    if (pf_last) begin
                        song_done = 1'b1;
                        state_nxt = ST_IDLE;
                    end else if (pf_full) begin
                        take              = 1'b1;
                        o_new_addr_valid  = 1'b1;
                        o_new_addr        = pf_entry.addr;
                        o_new_pattern_len = pf_entry.len;
                    end else begin
                        stall     = 1'b1;
                        state_nxt = ST_ARM;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Stop beats start; either one suppresses any load offered this cycle.
        if (i_start || i_stop) begin
            take              = 1'b0;
            stall             = 1'b0;
            song_done         = 1'b0;
            o_new_addr_valid  = 1'b0;
            o_new_addr        = '0;
            o_new_pattern_len = '0;
            state_nxt         = i_stop ? ST_IDLE : ST_FETCH;
        end
    end

    always_comb begin
        o_order_addr = '0;
        if (state == ST_FETCH) begin
            o_order_addr = idx;
        end else if (pf_req) begin
            o_order_addr = pf_idx;
        end
    end

    assign o_playing     = playing;
    assign o_order_index = idx;

endmodule

// File: doc/pattern_scheduler.md
# pattern_scheduler

Song-level controller for `note_sequencer`. It walks an order ROM of pattern entries, each holding a start address, a note count and a duration in note strobes. It drives the sequencer's pattern-load port (`new_addr` / `new_pattern_len` / `new_addr_valid`) so each pattern switch lands exactly on a note strobe. The next entry is prefetched during playback, which keeps back-to-back patterns gapless; the song loops or stops at an end-flagged entry.

## Interface
- `ORDER_AW`, default 4: order ROM address width (up to 16 entries).
- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset. Synchronous, active-high, on clock `i_clk`.
- `i_start`  in  1  single-cycle pulse. Starts, or restarts, the song at order index 0.
- `i_stop`  in  1  single-cycle pulse. Returns the block to IDLE.
- `i_loop_en`  in  1  level. When 1, wrap to index 0 after an end-flagged entry; when 0, stop there.
- `i_note_stb`  in  1  note-tick strobe, shared with `note_sequencer`.
- `o_order_addr`  out  ORDER_AW  order ROM address (synchronous ROM).
- `i_order_data`  in  24  order ROM data, valid 1 cycle after the address.
  - `[4:0]` pattern start address.
  - `[9:5]` pattern length.
  - `[21:10]` duration in strobes (12 bits).
  - `[22]` end flag.
  - `[23]` reserved.
- `o_new_addr`  out  5  to the sequencer's `i_new_addr`.
- `o_new_pattern_len`  out  5  to the sequencer's `i_new_pattern_len`.
- `o_new_addr_valid`  out  1  to the sequencer's `i_new_addr_valid`. Sampled only on `i_note_stb` cycles.
- `o_playing`  out  1  high from the first pattern load until stop or song end.
- `o_order_index`  out  ORDER_AW  index of the pattern currently playing.

## Operation
- Main FSM states: IDLE, FETCH, LATCH, ARM, PLAY.
- IDLE:
  - Outputs are 0.
  - `i_start` moves to FETCH with index 0.
- FETCH:
  - Drives `o_order_addr` with the index.
  - Moves to LATCH.
- LATCH:
  - Captures `i_order_data` into the current-entry registers.
  - A duration of 0 is treated as 1.
  - Moves to ARM.
- ARM:
  - `o_new_addr_valid` is 1.
  - On `i_note_stb`: the load is consumed. Tick counter is set to 0, `o_playing` to 1, and the state moves to PLAY.
- PLAY:
  - Each `i_note_stb` increments the tick counter.
  - The boundary is the strobe on which `tick_cnt == dur-1`. That strobe is itself the load strobe for the next pattern.
- Prefetch sub-FSM, running only in PLAY, states EMPTY, REQ, WAIT, FULL:
  - The next index is computed first:
    - If the current entry has its end flag set and `i_loop_en` = 1, next index = 0.
    - If the current entry has its end flag set and `i_loop_en` = 0, there is no next entry (song end).
    - Otherwise next index = index+1, wrapping mod 2^ORDER_AW.
  - EMPTY→REQ drives the next address. REQ→WAIT. WAIT captures the shadow entry and moves to FULL.
  - The prefetch is complete 3 cycles after PLAY entry.
- Boundary strobe with the shadow entry FULL:
  - `o_new_addr_valid` = 1 combinationally, from the shadow registers, during that strobe cycle.
  - On that strobe the shadow entry moves into current, `o_order_index` updates, the tick counter resets to 0, and prefetch returns to EMPTY.
- Boundary strobe at song end: on that strobe the block goes to IDLE and `o_playing` drops to 0.
- Boundary strobe with the shadow entry not yet FULL (strobe spacing under 4 cycles):
  - The block moves to ARM and loads on the first later strobe.
  - The tick counter holds at `dur-1`, with no wrap.
- `i_loop_en` is sampled when the prefetch computes the next index.
- `i_stop` in any state goes to IDLE next cycle. All outputs are 0 and the prefetch state is cleared.
- `i_start` and `i_stop` in the same cycle: stop wins.
- `i_start` while not IDLE restarts at FETCH with index 0 and drops `o_playing`.
- `i_rst` mid-operation has the same effect as stop and clears all registers.

## Timing
- Reset values:
  - FSM = IDLE, prefetch = EMPTY, all counters = 0.
  - `o_new_addr_valid` = 0, `o_playing` = 0, `o_order_index` = 0, `o_new_addr` = 0, `o_new_pattern_len` = 0, `o_order_addr` = 0.
- Start latency: `i_start` at cycle T puts the block in ARM at T+3, with valid high from T+3.
- The load happens on the first `i_note_stb` at or after T+3.
- `o_new_addr_valid` is never high outside ARM or a PLAY boundary strobe.
- A pattern with duration D occupies exactly D strobes, counting its own load strobe.
- `o_order_index` updates on the load strobe edge.

## Structure
- Shared package `apu_pkg` holds:
  - the order entry field offsets and widths;
  - the FSM and prefetch state enums;
  - the 12-bit duration width constant.
- One sub-module, `order_prefetch`. It contains the prefetch sub-FSM plus the shadow registers, and exposes these signals:
  - `req`
  - `next_idx`
  - `full`
  - `entry`
  - `consume`

## Test plan
- Entries 0 and 1: {addr 0, len 4, dur 3} and {addr 8, len 2, dur 2, end}, loop_en=1, strobe every 8 cycles, then start.
  - Required: loads at strobes 1, 4 and 6, carrying addresses 0, 8 and 0.
  - Required: `o_order_index` goes 0, 1, 0.
- The same song with `loop_en`=0.
  - Required: after strobe 5, `o_playing`=0 and there is no further valid.
- Entry with dur=0.
  - Required: it behaves as dur 1, a new load on every strobe.
- Strobes every 2 cycles.
  - Required: ARM is entered at the boundary, the load is deferred one strobe, and there is no double load.
- `i_stop` on the same cycle as a boundary strobe, then a later `i_start` together with `i_stop`.
  - Required: IDLE in both cases, `o_new_addr_valid` = 0.
- `i_rst` mid-PLAY with the prefetch in WAIT.
  - Required: all outputs 0 next cycle.
  - Required: a following start fetches index 0.
